// File: rtl/dsp_mac_pkg.sv
// Shared FSM state encoding and default widths for the MAC sequencer.
// P_W is A_W+B_W so a single full-width product never overflows the accumulator.
package dsp_mac_pkg;

  localparam int A_W = 20;
  localparam int B_W = 18;
  localparam int P_W = A_W + B_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dsp_mac_unit.sv
// Signed multiply feeding a registered accumulator.
// Wraps two's complement modulo 2^P_W; clr takes priority over en.
module dsp_mac_unit #(
  parameter int A_W = dsp_mac_pkg::A_W,
  parameter int B_W = dsp_mac_pkg::B_W,
  parameter int P_W = dsp_mac_pkg::P_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  sub,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [P_W-1:0] acc
);

  logic signed [A_W+B_W-1:0] prod;
  logic signed [P_W-1:0]     prod_ext;

  assign prod     = a * b;
  assign prod_ext = P_W'(prod);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
    end
  end

endmodule

// File: rtl/dsp_mac_seq_ctrl.sv
// Job sequencer for a multiply-accumulate datapath: counts operand beats,
// then holds the result until it is consumed.
//   state | meaning
//   IDLE  | waiting for start; accumulator shows last result (0 after reset)
//   RUN   | accepting operand pairs until remaining count hits 0
//   DONE  | result valid on P, held until res_ready
module dsp_mac_seq_ctrl #(
  parameter int A_W   = dsp_mac_pkg::A_W,
  parameter int B_W   = dsp_mac_pkg::B_W,
  parameter int P_W   = dsp_mac_pkg::P_W,
  parameter int LEN_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  subtract,
  output logic                  busy,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic signed [A_W-1:0] A,
  input  logic signed [B_W-1:0] B,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic signed [P_W-1:0] P
);

  import dsp_mac_pkg::*;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             sub_q, sub_nxt;
  logic             clr, en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sub_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sub_q <= sub_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sub_nxt   = sub_q;
    clr       = 1'b0;
    en        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          sub_nxt   = subtract;
          cnt_nxt   = len;
          state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (op_valid) begin
          en      = 1'b1;
          cnt_nxt = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == RUN) || (state == DONE);
  assign op_ready  = (state == RUN);
  assign res_valid = (state == DONE);

  dsp_mac_unit #(
    .A_W(A_W),
    .B_W(B_W),
    .P_W(P_W)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (en),
    .sub  (sub_q),
    .a    (A),
    .b    (B),
    .acc  (P)
  );

endmodule

// File: tb/tb_dsp_mac_seq_ctrl.sv
// Scenario bench for dsp_mac_seq_ctrl: expected results are queued when a job
// is started and popped when res_valid is observed. Inputs change on negedge.
module tb_dsp_mac_seq_ctrl;
  import dsp_mac_pkg::*;

  localparam int LEN_W = 6;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic [LEN_W-1:0]      len = '0;
  logic                  subtract = 1'b0;
  logic                  op_valid = 1'b0;
  logic signed [A_W-1:0] A = '0;
  logic signed [B_W-1:0] B = '0;
  logic                  res_ready = 1'b0;
  logic                  busy, op_ready, res_valid;
  logic signed [P_W-1:0] P;

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [P_W-1:0] exp_q[$];
  logic signed [P_W-1:0] exp;

  dsp_mac_seq_ctrl #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .subtract(subtract),
    .busy(busy), .op_valid(op_valid), .op_ready(op_ready), .A(A), .B(B),
    .res_valid(res_valid), .res_ready(res_ready), .P(P)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; len = 6'd3; op_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, op_ready, res_valid} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, op_ready, res_valid});
    end
    n_cmp++;
    if (P !== '0) begin n_bad++; $display("FAIL reset_p: got %0d want 0", P); end
    start = 1'b0; op_valid = 1'b0; len = '0;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, res_valid} !== 2'b00 || P !== '0) begin
      n_bad++; $display("FAIL reset_release: busy=%b res_valid=%b P=%0d want 0 0 0", busy, res_valid, P);
    end
  endtask

  task automatic test_single();
    start = 1'b1; len = 6'd1; subtract = 1'b0;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(38'sd10);
    n_cmp++;
    if ({busy, op_ready, res_valid} !== 3'b110) begin
      n_bad++; $display("FAIL single_run: got %b want 110", {busy, op_ready, res_valid});
    end
    op_valid = 1'b1; A = 20'sd5; B = 18'sd2;
    @(negedge clk);
    op_valid = 1'b0;
    n_cmp++;
    if ({busy, op_ready, res_valid} !== 3'b101) begin
      n_bad++; $display("FAIL single_latency: got %b want 101", {busy, op_ready, res_valid});
    end
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("FAIL single_p: no expected entry"); end
    else begin
      exp = exp_q.pop_front();
      if (P !== exp) begin n_bad++; $display("FAIL single_p: got %0d want %0d", P, exp); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_cmp++;
    if ({busy, op_ready, res_valid} !== 3'b000) begin
      n_bad++; $display("FAIL single_release: got %b want 000", {busy, op_ready, res_valid});
    end
  endtask

  task automatic test_subtract_gap();
    start = 1'b1; len = 6'd3; subtract = 1'b1;
    @(negedge clk);
    start = 1'b0; len = 6'd7; subtract = 1'b0;
    exp_q.push_back(38'sd9);
    n_cmp++;
    if (op_ready !== 1'b1) begin n_bad++; $display("FAIL sub_ready_b1: got %b want 1", op_ready); end
    op_valid = 1'b1; A = 20'sd5; B = 18'sd2;
    @(negedge clk);
    op_valid = 1'b0; A = -20'sd99; B = 18'sd99;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({op_ready, res_valid} !== 2'b10 || P !== -38'sd10) begin
        n_bad++; $display("FAIL sub_gap%0d: ready=%b valid=%b P=%0d want 1 0 -10", i, op_ready, res_valid, P);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (op_ready !== 1'b1) begin n_bad++; $display("FAIL sub_ready_b2: got %b want 1", op_ready); end
    op_valid = 1'b1; A = -20'sd3; B = 18'sd4;
    @(negedge clk);
    n_cmp++;
    if (op_ready !== 1'b1) begin n_bad++; $display("FAIL sub_ready_b3: got %b want 1", op_ready); end
    A = 20'sd7; B = -18'sd1;
    @(negedge clk);
    op_valid = 1'b0;
    n_cmp++;
    if ({op_ready, res_valid} !== 2'b01) begin
      n_bad++; $display("FAIL sub_done: got %b want 01", {op_ready, res_valid});
    end
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("FAIL sub_p: no expected entry"); end
    else begin
      exp = exp_q.pop_front();
      if (P !== exp) begin n_bad++; $display("FAIL sub_p: got %0d want %0d", P, exp); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    start = 1'b1; len = 6'd0; subtract = 1'b1;
    exp_q.push_back('0);
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({busy, op_ready, res_valid} !== 3'b101) begin
      n_bad++; $display("FAIL zero_done: got %b want 101", {busy, op_ready, res_valid});
    end
    op_valid = 1'b1; A = 20'sd5; B = 18'sd2;
    @(negedge clk);
    n_cmp++;
    if ({op_ready, res_valid} !== 2'b01) begin
      n_bad++; $display("FAIL zero_ignore_op: got %b want 01", {op_ready, res_valid});
    end
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("FAIL zero_p: no expected entry"); end
    else begin
      exp = exp_q.pop_front();
      if (P !== exp) begin n_bad++; $display("FAIL zero_p: got %0d want %0d", P, exp); end
    end
    op_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_wrap_backpressure();
    longint exp_l;
    logic signed [P_W-1:0] held;
    exp_l = -64'sd137438953472;
    start = 1'b1; len = 6'd2; subtract = 1'b0;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(exp_l[P_W-1:0]);
    held = exp_l[P_W-1:0];
    op_valid = 1'b1; A = -20'sd524288; B = -18'sd131072;
    @(negedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({busy, op_ready, res_valid} !== 3'b101 || P !== held) begin
        n_bad++; $display("FAIL hold%0d: flags=%b P=%0d want 101 %0d", i, {busy, op_ready, res_valid}, P, held);
      end
      start = ~start; len = 6'd1;
      @(negedge clk);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("FAIL wrap_p: no expected entry"); end
    else begin
      exp = exp_q.pop_front();
      if (P !== exp) begin n_bad++; $display("FAIL wrap_p: got %0d want %0d", P, exp); end
    end
    res_ready = 1'b1; start = 1'b1; len = 6'd1; subtract = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    n_cmp++;
    if ({busy, res_valid} !== 2'b00 || P !== held) begin
      n_bad++; $display("FAIL b2b_idle: busy=%b valid=%b P=%0d want 0 0 %0d", busy, res_valid, P, held);
    end
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(-38'sd42);
    n_cmp++;
    if (op_ready !== 1'b1 || P !== '0) begin
      n_bad++; $display("FAIL b2b_start: ready=%b P=%0d want 1 0", op_ready, P);
    end
    op_valid = 1'b1; A = -20'sd6; B = 18'sd7;
    @(negedge clk);
    op_valid = 1'b0;
    n_cmp++;
    if (exp_q.size() == 0 || res_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_p: valid=%b want 1 with expected entry", res_valid);
    end else begin
      exp = exp_q.pop_front();
      if (P !== exp) begin n_bad++; $display("FAIL b2b_p: got %0d want %0d", P, exp); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; len = 6'd3; subtract = 1'b0;
    @(negedge clk);
    start = 1'b0;
    op_valid = 1'b1; A = 20'sd5; B = 18'sd2;
    @(negedge clk);
    op_valid = 1'b0;
    n_cmp++;
    if (op_ready !== 1'b1 || P !== 38'sd10) begin
      n_bad++; $display("FAIL mid_run: ready=%b P=%0d want 1 10", op_ready, P);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, op_ready, res_valid} !== 3'b000 || P !== '0) begin
      n_bad++; $display("FAIL rst_async: flags=%b P=%0d want 000 0", {busy, op_ready, res_valid}, P);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, res_valid} !== 2'b00) begin
      n_bad++; $display("FAIL rst_resume_idle: got %b want 00", {busy, res_valid});
    end
    start = 1'b1; len = 6'd1; subtract = 1'b0;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(38'sd10);
    op_valid = 1'b1; A = 20'sd5; B = 18'sd2;
    @(negedge clk);
    op_valid = 1'b0;
    n_cmp++;
    if (exp_q.size() == 0 || res_valid !== 1'b1) begin
      n_bad++; $display("FAIL rst_new_job: valid=%b want 1 with expected entry", res_valid);
    end else begin
      exp = exp_q.pop_front();
      if (P !== exp) begin n_bad++; $display("FAIL rst_new_job: got %0d want %0d", P, exp); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_subtract_gap();
    test_zero_len();
    test_wrap_backpressure();
    test_reset_mid_run();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL leftover: %0d results never produced, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dsp_mac_seq_ctrl.md
DSP_MAC_SEQ_CTRL -- requirements
Module: dsp_mac_seq_ctrl

Interface
REQ-001 The block SHALL have parameter A_W, default 20: signed multiplicand width.
REQ-002 The block SHALL have parameter B_W, default 18: signed multiplier width.
REQ-003 The block SHALL have parameter P_W, default 38 (= A_W+B_W): accumulator and result width.
REQ-004 The block SHALL have parameter LEN_W, default 6: width of the job-length field; max job length is 2^LEN_W-1.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-006 The block SHALL have port reset, input, 1: reset, asynchronous and active-low.
REQ-007 The block SHALL have port start, input, 1: job request; sampled only in IDLE.
REQ-008 The block SHALL have port len, input, LEN_W: number of A*B terms in the job; sampled with start.
REQ-009 The block SHALL have port subtract, input, 1: job mode (0: P=P+A*B, 1: P=P-A*B); sampled with start.
REQ-010 The block SHALL have port busy, output, 1: high in RUN and DONE.
REQ-011 The block SHALL have port op_valid, input, 1: operand pair valid.
REQ-012 The block SHALL have port op_ready, output, 1: operand pair accepted when op_valid && op_ready.
REQ-013 The block SHALL have port A, input, A_W: signed operand A.
REQ-014 The block SHALL have port B, input, B_W: signed operand B.
REQ-015 The block SHALL have port res_valid, output, 1: result available.
REQ-016 The block SHALL have port res_ready, input, 1: result consumed when res_valid && res_ready.
REQ-017 The block SHALL have port P, output, P_W: signed accumulated result.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DONE; reset state is IDLE.
REQ-019 IDLE with start=1 and len!=0 SHALL, at the next edge: clear the accumulator to 0, latch subtract, load remaining count with len, and go to RUN.
REQ-020 IDLE with start=1 and len=0 SHALL, at the next edge: clear the accumulator and go directly to DONE (P=0).
REQ-021 op_ready SHALL be 1 only in RUN; op_valid outside RUN SHALL be ignored.
REQ-022 Each RUN handshake SHALL update the accumulator at that edge to acc + A*B (subtract=0) or acc - A*B (subtract=1), and SHALL decrement the remaining count.
REQ-023 The product SHALL be the full signed A_W+B_W product; accumulation SHALL wrap modulo 2^P_W (two's complement) with no saturation or flag.
REQ-024 Cycles in RUN with op_valid=0 SHALL stall the job with no state change.
REQ-025 The handshake that brings the remaining count to 0 SHALL move the FSM to DONE at the same edge, so res_valid=1 in the following cycle (latency 1 cycle after the last beat).
REQ-026 In DONE, res_valid SHALL be 1 and P SHALL hold the accumulator, stable until the handshake.
REQ-027 A DONE handshake SHALL return the FSM to IDLE at that edge; a new start SHALL be accepted no earlier than the following cycle.
REQ-028 start SHALL be ignored in RUN and DONE, and len/subtract changes after acceptance SHALL have no effect on the running job.
REQ-029 P SHALL show the live accumulator in all states, and SHALL be 0 in IDLE after reset until the first job.

Reset
REQ-030 Asserting reset (low) SHALL, immediately and independent of clk, set the FSM to IDLE, the accumulator and count to 0, the latched subtract to 0, and busy, op_ready, res_valid and P to 0.
REQ-031 Reset asserted mid-RUN or mid-DONE SHALL abandon the job with no result issued; operation SHALL resume normally at the first edge after deassertion.

Structure
REQ-032 Package dsp_mac_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default width constants A_W, B_W and P_W.
REQ-033 The datapath SHALL be one sub-module, dsp_mac_unit: signed multiply feeding a registered accumulator, with inputs clr, en and sub; dsp_mac_seq_ctrl holds only the FSM, counter and handshakes.

Verification
REQ-034 Bench: reset, then start len=1, subtract=0, A=5, B=2 -> res_valid one cycle after the beat; P=10.
REQ-035 Bench: start len=3, subtract=1, pairs (5,2), (-3,4), (7,-1), with a 2-cycle op_valid gap after the first -> P=9; op_ready high throughout RUN.
REQ-036 Bench: start len=0 -> DONE next cycle with P=0 and res_valid=1; no op_ready pulse.
REQ-037 Bench: len=2, A=-524288, B=-131072 twice -> P=-137438953472 (wrap at 2^37).
REQ-038 Bench: hold res_ready=0 for 5 cycles in DONE while pulsing start -> P and res_valid stable and start ignored; res_ready=1 -> IDLE next cycle.
REQ-039 Bench: reset low mid-RUN after 1 of 3 beats -> all outputs 0 immediately; a new job len=1 (5,2) -> P=10.
